// File: rtl/qadd_pkg.sv
// Shared word format for the sign-magnitude adder: one sign bit over an
// unsigned magnitude, plus the constants the datapath needs.
package qadd_pkg;

   localparam int N = 32;

   typedef struct packed {
      logic         sgn;
      logic [N-2:0] mag;
   } sm_t;

   localparam sm_t          SM_ZERO    = '0;
   localparam logic [N-2:0] SM_MAG_MAX = '1;

endpackage

// File: rtl/qadd_sm_lane.sv
// One lane of the sign-magnitude add/sub pipeline: stage 1 orders the
// magnitudes and resolves signs, stage 2 does the magnitude arithmetic.
module qadd_sm_lane
   import qadd_pkg::*;
#(
   parameter bit SAT = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load1,
   input  logic         load2,
   input  logic         op_sub,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] c,
   output logic         ovf
);

   sm_t          a_sm, b_sm;
   logic         a_sgn, b_sgn, a_big;
   logic [N-2:0] big_q, small_q;
   logic         eff_add_q, sgn_q;
   logic [N-1:0] sum;
   logic [N-2:0] mag_n;
   logic         ovf_n, sgn_n;

   assign a_sm = a;
   assign b_sm = b;

   // A zero magnitude never carries a sign, so -0 behaves exactly like +0.
   assign a_sgn = a_sm.sgn && (a_sm.mag != '0);
   assign b_sgn = (b_sm.sgn ^ op_sub) && (b_sm.mag != '0);
   assign a_big = (a_sm.mag >= b_sm.mag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         big_q     <= '0;
         small_q   <= '0;
         eff_add_q <= 1'b0;
         sgn_q     <= 1'b0;
      end else if (load1) begin
         big_q     <= a_big ? a_sm.mag : b_sm.mag;
         small_q   <= a_big ? b_sm.mag : a_sm.mag;
         eff_add_q <= (a_sgn == b_sgn);
         sgn_q     <= (a_sgn == b_sgn) ? a_sgn : (a_big ? a_sgn : b_sgn);
      end
   end

   assign sum = {1'b0, big_q} + {1'b0, small_q};

   always_comb begin
      mag_n = '0;
      ovf_n = 1'b0;
      if (eff_add_q) begin
         ovf_n = sum[N-1];
         mag_n = (SAT && sum[N-1]) ? SM_MAG_MAX : sum[N-2:0];
      end else begin
         mag_n = big_q - small_q;
      end
      sgn_n = sgn_q && (mag_n != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c   <= SM_ZERO;
         ovf <= 1'b0;
      end else if (load2) begin
         c   <= {sgn_n, mag_n};
         ovf <= ovf_n;
      end
   end

endmodule

// File: rtl/qadd_sm_pipe.sv
// Multi-lane 2-stage sign-magnitude adder/subtractor with saturation,
// per-lane overflow and a sticky overflow flag.
module qadd_sm_pipe
   import qadd_pkg::*;
#(
   parameter int Q     = 15,
   parameter int N     = qadd_pkg::N,
   parameter int LANES = 4,
   parameter bit SAT   = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               op_sub,
   input  logic [LANES*N-1:0] a,
   input  logic [LANES*N-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*N-1:0] c,
   output logic [LANES-1:0]   ovf,
   output logic               ovf_sticky,
   input  logic               clr_sticky
);

   // The lane datapath is sized from the package word width.
   if (N != qadd_pkg::N || Q >= N) begin : g_param_check
      $error("qadd_sm_pipe: N must equal qadd_pkg::N and Q must be below N");
   end

   logic s1_valid, s2_valid;
   logic en1, en2, load1, load2;

   // Handshake: a beat moves on in_valid && in_ready and leaves on
   // out_valid && out_ready; a stage advances when the one after it is empty
   // or advancing, so in_ready is combinational from out_ready and a stalled
   // output holds c/ovf/out_valid unchanged.
   assign en2       = !s2_valid || out_ready;
   assign en1       = !s1_valid || en2;
   assign in_ready  = en1;
   assign load1     = en1 && in_valid;
   assign load2     = en2 && s1_valid;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         if (en1) s1_valid <= in_valid;
         if (en2) s2_valid <= s1_valid;
         if (s2_valid && out_ready && (|ovf)) ovf_sticky <= 1'b1;
         else if (clr_sticky)                 ovf_sticky <= 1'b0;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      qadd_sm_lane #(.SAT(SAT)) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .load1  (load1),
         .load2  (load2),
         .op_sub (op_sub),
         .a      (a[i*N +: N]),
         .b      (b[i*N +: N]),
         .c      (c[i*N +: N]),
         .ovf    (ovf[i])
      );
   end

endmodule

// File: tb/tb_qadd_sm_pipe.sv
// Bench for qadd_sm_pipe: a saturating and a wrapping instance share stimulus;
// results are compared with a signed-integer reference model.
module tb_qadd_sm_pipe;

   localparam int N = 32;
   localparam int L = 4;
   localparam int W = L*N + L;

   logic           clk = 1'b0;
   logic           rst_n, in_valid, op_sub, out_ready, clr_sticky;
   logic [L*N-1:0] a, b;
   logic           in_ready, out_valid, ovf_sticky;
   logic [L*N-1:0] c;
   logic [L-1:0]   ovf;
   logic           in_ready_w, out_valid_w, ovf_sticky_w;
   logic [L*N-1:0] c_w;
   logic [L-1:0]   ovf_w;

   int checks = 0;
   int errors = 0;
   int out_count = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_w_q[$];
   logic         sticky_m = 1'b0;

   always #5 clk = ~clk;

   qadd_sm_pipe #(.SAT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .c(c), .ovf(ovf), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
   );

   qadd_sm_pipe #(.SAT(1'b0)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
      .c(c_w), .ovf(ovf_w), .ovf_sticky(ovf_sticky_w), .clr_sticky(clr_sticky)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: true signed sum, then clamp or wrap the magnitude to 31 bits.
   function automatic logic [N:0] ref_word(logic [N-1:0] x, logic [N-1:0] y, logic sub, bit sat);
      longint xv, yv, r, m;
      logic   o;
      xv = longint'(x[N-2:0]);
      yv = longint'(y[N-2:0]);
      if (x[N-1]) xv = -xv;
      if (y[N-1] ^ sub) yv = -yv;
      r = xv + yv;
      m = (r < 0) ? -r : r;
      o = (m > 64'h7FFF_FFFF);
      if (o) m = sat ? 64'h7FFF_FFFF : (m & 64'h7FFF_FFFF);
      return {o, (r < 0) && (m != 0), m[N-2:0]};
   endfunction

   function automatic logic [W-1:0] model_beat(logic [L*N-1:0] av, logic [L*N-1:0] bv, logic sub, bit sat);
      logic [W-1:0] r;
      logic [N:0]   w;
      r = '0;
      for (int i = 0; i < L; i++) begin
         w = ref_word(av[i*N +: N], bv[i*N +: N], sub, sat);
         r[L + i*N +: N] = w[N-1:0];
         r[i] = w[N];
      end
      return r;
   endfunction

   function automatic logic [N-1:0] rand_word();
      logic [N-1:0] v;
      v = $urandom;
      case ($urandom_range(0, 3))
         0:       v[N-2:0] = 31'h7FFF_FFFF - 31'($urandom_range(0, 3));
         1:       v[N-2:0] = 31'($urandom_range(0, 3));
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [L*N-1:0] rand_beat();
      logic [L*N-1:0] v;
      for (int i = 0; i < L; i++) v[i*N +: N] = rand_word();
      return v;
   endfunction

   // Scoreboard: pop on each output transfer, push on each input transfer.
   always @(negedge clk) begin
      logic [W-1:0] e;
      #1;
      if (!rst_n) begin
         sticky_m = 1'b0;
      end else begin
         check("sticky_sat", ovf_sticky, sticky_m);
         check("sticky_wrap", ovf_sticky_w, sticky_m);
         e = '0;
         if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL spurious_out: observed beat %h expected none", c);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("stream_c_sat", c, e[W-1:L]);
               check("stream_ovf_sat", ovf, e[L-1:0]);
               out_count++;
            end
         end
         if (out_valid_w && out_ready && exp_w_q.size() != 0) begin
            logic [W-1:0] ew;
            ew = exp_w_q.pop_front();
            check("stream_c_wrap", c_w, ew[W-1:L]);
            check("stream_ovf_wrap", ovf_w, ew[L-1:0]);
         end
         if (out_valid && out_ready && (|e[L-1:0])) sticky_m = 1'b1;
         else if (clr_sticky)                      sticky_m = 1'b0;
         if (in_valid && in_ready) begin
            exp_q.push_back(model_beat(a, b, op_sub, 1'b1));
            exp_w_q.push_back(model_beat(a, b, op_sub, 1'b0));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [L*N-1:0] bt_a[6], bt_b[6];
      logic           bt_op[6];
      logic [W-1:0]   e;
      int sent, base;

      rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0;
      out_ready = 1'b1; clr_sticky = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_c", c, '0);
      check("rst_ovf", ovf, '0);
      check("rst_sticky", ovf_sticky, 1'b0);
      @(negedge clk); rst_n = 1'b1;

      // Basic add, signed zero, saturate/wrap at the magnitude limit.
      @(negedge clk);
      in_valid = 1'b1; op_sub = 1'b0;
      a = {32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_8000, 32'h0000_8000};
      b = {32'h8000_0001, 32'h0000_0001, 32'h8000_8000, 32'h0000_4000};
      #1;
      check("t1_in_ready", in_ready, 1'b1);
      check("t1_in_ready_wrap", in_ready_w, 1'b1);
      @(negedge clk); in_valid = 1'b0; #1;
      check("t1_lat_early", out_valid, 1'b0);
      @(negedge clk); #1;
      check("t1_lat_valid", out_valid, 1'b1);
      check("t1_c_sat", c, {32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_C000});
      check("t1_ovf_sat", ovf, 4'b1100);
      check("t1_c_wrap", c_w, {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_C000});
      check("t1_ovf_wrap", ovf_w, 4'b1100);
      @(negedge clk); #1;
      check("t1_sticky_set", ovf_sticky, 1'b1);
      check("t1_drained", out_valid, 1'b0);

      // Subtraction, negative-zero inputs.
      @(negedge clk);
      in_valid = 1'b1; op_sub = 1'b1;
      a = {32'h0000_0005, 32'h8000_0000, 32'h0000_0000, 32'h0000_4000};
      b = {32'h0000_0005, 32'h8000_0005, 32'h0000_0000, 32'h0000_8000};
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); #1;
      check("t2_c", c, {32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h8000_4000});
      check("t2_ovf", ovf, 4'b0000);

      // Clear colliding with an overflowing transfer: set wins.
      @(negedge clk);
      in_valid = 1'b1; op_sub = 1'b0;
      a = {32'h0, 32'h7FFF_FFFF, 32'h0, 32'h0};
      b = {32'h0, 32'h0000_0001, 32'h0, 32'h0};
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); clr_sticky = 1'b1; #1;
      check("t5_ovf", ovf, 4'b0100);
      @(negedge clk); clr_sticky = 1'b0; #1;
      check("t5_set_wins", ovf_sticky, 1'b1);
      @(negedge clk); clr_sticky = 1'b1;
      @(negedge clk); clr_sticky = 1'b0; #1;
      check("t5_cleared", ovf_sticky, 1'b0);

      // Backpressure: six beats with the output stalled for five cycles.
      for (int i = 0; i < 6; i++) begin
         bt_a[i] = rand_beat(); bt_b[i] = rand_beat(); bt_op[i] = 1'($urandom_range(0, 1));
      end
      sent = 0; base = out_count;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 5);
         in_valid  = (sent < 6);
         if (sent < 6) begin
            a = bt_a[sent]; b = bt_b[sent]; op_sub = bt_op[sent];
         end
         #1;
         if (cyc >= 2 && cyc <= 4) begin
            e = model_beat(bt_a[0], bt_b[0], bt_op[0], 1'b1);
            check("t4_in_ready_low", in_ready, 1'b0);
            check("t4_hold_valid", out_valid, 1'b1);
            check("t4_hold_c", c, e[W-1:L]);
         end
         if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      check("t4_sent", sent, 6);
      check("t4_out_count", out_count - base, 6);
      check("t4_queue_empty", exp_q.size(), 0);

      // Reset with two beats in flight.
      @(negedge clk); in_valid = 1'b1; a = rand_beat(); b = rand_beat();
      @(negedge clk); a = rand_beat(); b = rand_beat();
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      exp_q.delete(); exp_w_q.delete();
      #1;
      check("t6_rst_valid", out_valid, 1'b0);
      check("t6_rst_c", c, '0);
      check("t6_rst_ovf", ovf, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check("t6_no_stale", out_valid, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b1; op_sub = 1'b0;
      a = {32'h0, 32'h0, 32'h8000_0003, 32'h0000_0010};
      b = {32'h0, 32'h0, 32'h0000_0001, 32'h0000_0020};
      @(negedge clk); in_valid = 1'b0; #1;
      check("t6_lat_early", out_valid, 1'b0);
      @(negedge clk); #1;
      check("t6_lat_valid", out_valid, 1'b1);
      check("t6_c", c, {32'h0, 32'h0, 32'h8000_0002, 32'h0000_0030});

      // Random traffic with random bubbles, backpressure and clears.
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         clr_sticky = ($urandom_range(0, 7) == 0);
         op_sub     = 1'($urandom_range(0, 1));
         a = rand_beat(); b = rand_beat();
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
      repeat (6) @(negedge clk);
      #2;
      check("final_queue_empty", exp_q.size(), 0);
      check("final_wrap_queue_empty", exp_w_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
